run_sequencer: RTL

Host-facing run controller that sits directly upstream of the processor core. It converts a host start request into a clean, multi-cycle core reset followed by a run phase. It watches the core's `done` flag, and reports completion, elapsed run cycles and a watchdog timeout back to the host. While idle or finished, it keeps the core parked in reset so instruction fetch never free-runs.

---
 rtl/run_pkg.sv | 19 +
 rtl/rise_detect.sv | 31 +++
 rtl/run_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_pkg : shared state type and default sizing for run_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package run_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } run_state_t;

   localparam int unsigned RST_CYC_DEF = 2;
   localparam int unsigned CW_DEF      = 16;

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rise_detect : registered level with a rising-edge pulse (level & ~level_q)
// Rev 1.0
// ---------------------------------------------------------------------------
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic level_q;
   logic level_d;

   always_comb begin
      level_d = level;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign rise = level & ~level_q;

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_sequencer : host start -> timed core reset -> run with watchdog/report
// Rev 1.0
// ---------------------------------------------------------------------------
module run_sequencer
   import run_pkg::*;
#(
   parameter int unsigned RST_CYC = RST_CYC_DEF,
   parameter int unsigned CW      = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          core_done,
   output logic          core_reset,
   output logic          busy,
   output logic          ack,
   output logic          timeout,
   output logic [CW-1:0] cycles
);

   localparam logic [3:0]    RST_LAST = 4'(RST_CYC - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   run_state_t    state_q, state_d;
   logic [3:0]    rst_cnt_q, rst_cnt_d;
   logic [CW-1:0] cnt_q, cnt_d, next_cnt;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          timeout_q, timeout_d;
   logic          ack_q, ack_d;
   logic          core_reset_q, core_reset_d;
   logic          busy_q, busy_d;
   logic          start;

   rise_detect u_req_rise (
      .clk   (clk),
      .reset (reset),
      .level (req),
      .rise  (start)
   );

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cnt_d     = cnt_q;
      cycles_d  = cycles_q;
      timeout_d = timeout_q;
      next_cnt  = cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            rst_cnt_d = '0;
            if (start) begin
               state_d   = RESET;
               timeout_d = 1'b0;
            end
         end
         RESET: begin
            cnt_d = '0;
            if (rst_cnt_q == RST_LAST) begin
               state_d = RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + 4'd1;
            end
         end
         RUN: begin
            cnt_d = next_cnt;
            // done wins over a watchdog expiry landing on the same cycle
            if (core_done) begin
               cycles_d = next_cnt;
               state_d  = DONE;
            end else if (next_cnt == CNT_MAX) begin
               cycles_d  = next_cnt;
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // outputs decoded from the next state so they are registered alongside it
      core_reset_d = (state_d != RUN);
      busy_d       = (state_d == RESET) || (state_d == RUN);
      ack_d        = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rst_cnt_q    <= '0;
         cnt_q        <= '0;
         cycles_q     <= '0;
         timeout_q    <= 1'b0;
         ack_q        <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         cnt_q        <= cnt_d;
         cycles_q     <= cycles_d;
         timeout_q    <= timeout_d;
         ack_q        <= ack_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
      end
   end

   assign core_reset = core_reset_q;
   assign busy       = busy_q;
   assign ack        = ack_q;
   assign timeout    = timeout_q;
   assign cycles     = cycles_q;

endmodule
`default_nettype wire
